// File: rtl/time_set_editor_pkg.sv
// Shared types and elaboration helpers for the digit-by-digit value editor.
package time_set_editor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EDIT,
        ST_COMMIT
    } edit_state_e;

    // MM:SS layout, most significant digit in the top field.
    localparam logic [15:0] MMSS_BASES = {4'd6, 4'd10, 4'd6, 4'd10};

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int unsigned cycles_per_ms(input int unsigned clk_hz);
        return (clk_hz / 1000 == 0) ? 1 : clk_hz / 1000;
    endfunction

endpackage

// File: rtl/time_set_editor_hold_repeat.sv
// Button press edge detector with hold-delay auto-repeat; emits one step pulse per action.
module time_set_editor_hold_repeat
    import time_set_editor_pkg::*;
#(
    parameter int unsigned DELAY_CYC = 10,
    parameter int unsigned RATE_CYC  = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic btn_i,
    input  logic clr_i,
    output logic step_o
);

    localparam int unsigned CW = clog2_min1((DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC);
    localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY_CYC - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(RATE_CYC - 1);

    logic          btn_q;
    logic          rep_q, rep_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= 1'b0;
            rep_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            btn_q <= btn_i;
            rep_q <= rep_d;
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts held cycles since the last step; rep_q selects delay vs. repeat period.
    always_comb begin
        cnt_d  = cnt_q;
        rep_d  = rep_q;
        step_o = 1'b0;
        if (!en_i || !btn_i || clr_i) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (!btn_q) begin
            step_o = 1'b1;
            cnt_d  = '0;
            rep_d  = 1'b0;
        end else if (!rep_q) begin
            if (cnt_q == DELAY_LAST) begin
                step_o = 1'b1;
                cnt_d  = '0;
                rep_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q == RATE_LAST) begin
                step_o = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_set_editor.sv
// Digit-by-digit value editor: load, navigate, step with per-digit base, blink, commit on exit.
module time_set_editor
    import time_set_editor_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned BITS_PER_DIGIT  = 4,
    parameter logic [NUM_DIGITS*BITS_PER_DIGIT-1:0] DIGIT_BASES = MMSS_BASES,
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned BLINK_HZ        = 5,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_HZ       = 10,
    parameter bit          WRAP_EN         = 1'b1,
    parameter bit          CARRY_EN        = 1'b0,
    localparam int unsigned NB = NUM_DIGITS * BITS_PER_DIGIT,
    localparam int unsigned SW = clog2_min1(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  edit_req,
    input  logic [NB-1:0]         load_value,
    input  logic                  up,
    input  logic                  down,
    input  logic                  left,
    input  logic                  right,
    output logic                  editing,
    output logic [SW-1:0]         sel,
    output logic [NB-1:0]         value_out,
    output logic [NUM_DIGITS-1:0] blank_mask,
    output logic                  commit_valid,
    output logic [NB-1:0]         commit_value
);

    localparam int unsigned B         = BITS_PER_DIGIT;
    localparam int unsigned BLINK_RAW = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned BLINK_CYC = (BLINK_RAW == 0) ? 1 : BLINK_RAW;
    localparam int unsigned DELAY_CYC = REPEAT_DELAY_MS * cycles_per_ms(CLK_HZ);
    localparam int unsigned RATE_RAW  = CLK_HZ / REPEAT_HZ;
    localparam int unsigned RATE_CYC  = (RATE_RAW == 0) ? 1 : RATE_RAW;
    localparam int unsigned BW        = clog2_min1(BLINK_CYC);
    localparam logic [SW-1:0] SEL_MAX = SW'(NUM_DIGITS - 1);

    edit_state_e   state_q, state_d;
    logic [NB-1:0] value_q, value_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [NB-1:0] commit_value_q, commit_value_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          left_q, right_q;

    logic          in_edit, up_step, down_step, inc, dec;
    logic          nav_ok, left_press, right_press, moved;
    logic [NB-1:0] stepped, loaded;

    assign in_edit = (state_q == ST_EDIT);

    time_set_editor_hold_repeat #(.DELAY_CYC(DELAY_CYC), .RATE_CYC(RATE_CYC)) u_up_rep (
        .clk(clk), .rst(rst), .en_i(in_edit), .btn_i(up), .clr_i(up & down), .step_o(up_step)
    );

    time_set_editor_hold_repeat #(.DELAY_CYC(DELAY_CYC), .RATE_CYC(RATE_CYC)) u_down_rep (
        .clk(clk), .rst(rst), .en_i(in_edit), .btn_i(down), .clr_i(up & down), .step_o(down_step)
    );

    // A falling edit_req wins over a step arriving on the same edge.
    assign inc = up_step & in_edit & edit_req;
    assign dec = down_step & in_edit & edit_req;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        logic [B-1:0] cur, lim, ld, nxt;
        logic         trig, at_edge;

        assign cur     = value_q[i*B +: B];
        assign lim     = DIGIT_BASES[i*B +: B] - 1'b1;
        assign at_edge = inc ? (cur == lim) : (cur == '0);
        assign ld      = (load_value[i*B +: B] > lim) ? lim : load_value[i*B +: B];

        // Carry/borrow enters digit i only from a wrapping digit at or above the selection.
        if (i == 0) begin : g_first
            assign trig = (inc | dec) && (sel_q == SW'(0));
        end else begin : g_rest
            assign trig = (inc | dec) &&
                          ((sel_q == SW'(i)) ||
                           (CARRY_EN && WRAP_EN && (sel_q < SW'(i)) &&
                            g_dig[i-1].trig && g_dig[i-1].at_edge));
        end

        always_comb begin
            nxt = cur;
            if (trig) begin
                if (inc) nxt = at_edge ? (WRAP_EN ? '0 : cur) : cur + 1'b1;
                else     nxt = at_edge ? (WRAP_EN ? lim : cur) : cur - 1'b1;
            end
        end

        assign stepped[i*B +: B] = nxt;
        assign loaded[i*B +: B]  = ld;
    end

    assign nav_ok      = edit_req && !(up || down);
    assign left_press  = nav_ok && left && !left_q && !right;
    assign right_press = nav_ok && right && !right_q && !left;
    assign moved       = left_press || right_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            value_q        <= '0;
            sel_q          <= SEL_MAX;
            commit_value_q <= '0;
            blink_cnt_q    <= '0;
            phase_q        <= 1'b0;
            left_q         <= 1'b0;
            right_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            value_q        <= value_d;
            sel_q          <= sel_d;
            commit_value_q <= commit_value_d;
            blink_cnt_q    <= blink_cnt_d;
            phase_q        <= phase_d;
            left_q         <= left;
            right_q        <= right;
        end
    end

    always_comb begin
        state_d        = state_q;
        value_d        = value_q;
        sel_d          = sel_q;
        commit_value_d = commit_value_q;
        blink_cnt_d    = blink_cnt_q;
        phase_d        = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (edit_req) begin
                    state_d     = ST_EDIT;
                    value_d     = loaded;
                    sel_d       = SEL_MAX;
                    blink_cnt_d = '0;
                    phase_d     = 1'b0;
                end
            end
            ST_EDIT: begin
                if (!edit_req) begin
                    state_d        = ST_COMMIT;
                    commit_value_d = value_q;
                end else begin
                    value_d = stepped;
                    if (left_press && sel_q != SEL_MAX)    sel_d = sel_q + 1'b1;
                    else if (right_press && sel_q != '0)   sel_d = sel_q - 1'b1;
                    if (inc || dec || moved) begin
                        blink_cnt_d = '0;
                        phase_d     = 1'b0;
                    end else if (blink_cnt_q == BW'(BLINK_CYC - 1)) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign editing      = in_edit;
    assign sel          = sel_q;
    assign value_out    = value_q;
    assign commit_valid = (state_q == ST_COMMIT);
    assign commit_value = commit_value_q;
    assign blank_mask   = (in_edit && phase_q) ? (NUM_DIGITS'(1) << sel_q) : '0;

endmodule
